serializer: RTL and testbench

//  Parallel-to-serial converter; the transmit-side counterpart of the 16-bit deserializer.
//  - Captures one parallel word plus a bit count in a single handshake cycle.
//  - Shifts the word out MSB first, one bit per clock, each bit qualified by ser_data_val_o.
//  - Sits in front of any serial sink using the per-bit valid convention. With mod=0, a

---
 rtl/serializer_if.sv | 33 +++
 rtl/serializer.sv | 76 +++++++
 tb/tb_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serializer_if.sv
// Handshake bundle between a parallel word source and the serializer.
// The source drives the word, bit count and strobe; the serializer returns the serial stream.
interface serializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o
  );

endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word plus bit count in one cycle and
// shifts it out MSB first, one valid-qualified bit per clock.
module serializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input logic         clk_i,
  input logic         srst_i,
  serializer_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [MOD_W-1:0]  bit_cnt;
  logic              ser_data;
  logic              ser_val;
  logic              mod_ok;
  logic [MOD_W-1:0]  last_idx;

  // A zero count means a full word; counts below MIN_LEN (other than zero) are dropped.
  always_comb begin
    mod_ok   = (bus.data_mod_i == '0) || (bus.data_mod_i >= MOD_W'(MIN_LEN));
    last_idx = (bus.data_mod_i == '0) ? MOD_W'(DATA_W - 1)
                                      : bus.data_mod_i - MOD_W'(1);
  end

  // The MSB goes straight to the output register on accept, so the shift register
  // holds only the bits still to come and the first bit appears one cycle later.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      ser_data  <= 1'b0;
      ser_val   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_val_i && mod_ok) begin
            state     <= SHIFT;
            shift_reg <= bus.data_i << 1;
            bit_cnt   <= last_idx;
            ser_data  <= bus.data_i[DATA_W-1];
            ser_val   <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state    <= IDLE;
            ser_data <= 1'b0;
            ser_val  <= 1'b0;
          end else begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - MOD_W'(1);
            ser_data  <= shift_reg[DATA_W-1];
          end
        end
        default: begin
          state   <= IDLE;
          ser_val <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_data_o     = ser_data;
  assign bus.ser_data_val_o = ser_val;
  assign bus.busy_o         = ser_val;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the expected bit stream.
module tb_serializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                n;
  } word_t;

  logic clk_i = 1'b0;
  logic srst_i;
  int   compared   = 0;
  int   mismatched = 0;

  logic   expQ[$];
  word_t  sentQ[$];
  logic [31:0] rxWord = '0;
  int          rxCnt  = 0;

  always #5 clk_i = ~clk_i;

  serializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  serializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(3)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus)
  );

  // Reference model: the queue front is the bit currently on the line; an accept
  // appends the whole word, and acceptance is only possible once the line is empty.
  always @(posedge clk_i) begin
    int n;
    if (srst_i) begin
      expQ.delete();
      sentQ.delete();
    end else if (expQ.size() > 0) begin
      void'(expQ.pop_front());
    end else if (bus.data_val_i && (bus.data_mod_i == 0 || bus.data_mod_i >= 3)) begin
      n = (bus.data_mod_i == 0) ? DATA_W : int'(bus.data_mod_i);
      for (int i = 0; i < n; i++) expQ.push_back(bus.data_i[DATA_W-1-i]);
      sentQ.push_back('{d: bus.data_i, n: n});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Per-cycle output check plus reassembly of complete words on the receive side.
  task automatic nextCycle();
    logic expVal;
    logic expBit;
    @(negedge clk_i);
    expVal = (expQ.size() > 0);
    expBit = expVal ? expQ[0] : 1'b0;
    checkOutput("ser_data_val", {31'd0, bus.ser_data_val_o}, {31'd0, expVal});
    checkOutput("busy", {31'd0, bus.busy_o}, {31'd0, expVal});
    checkOutput("ser_data", {31'd0, bus.ser_data_o}, {31'd0, expBit});
    if (sentQ.size() == 0) begin
      rxCnt  = 0;
      rxWord = '0;
    end else if (bus.ser_data_val_o === 1'b1) begin
      rxWord = {rxWord[30:0], bus.ser_data_o};
      rxCnt++;
      if (rxCnt == sentQ[0].n) begin
        checkOutput("word", rxWord, 32'(sentQ[0].d >> (DATA_W - sentQ[0].n)));
        void'(sentQ.pop_front());
        rxCnt  = 0;
        rxWord = '0;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic val,
                               input logic [DATA_W-1:0] data, input logic [MOD_W-1:0] mod);
    srst_i         = rst;
    bus.data_val_i = val;
    bus.data_i     = data;
    bus.data_mod_i = mod;
  endtask

  initial begin
    logic [DATA_W-1:0] hold;
    applyStimulus(1'b1, 1'b1, 16'hA53C, 4'd0);

    // Reset held with a pending request: nothing must start.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 16'hA53C, 4'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Full word.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'hA53C, 4'd0);
    for (int i = 0; i < 19; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    end

    // Short word.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'hF000, 4'd5);
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end

    // Too-short counts are dropped.
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        nextCycle();
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 4'(m));
      end
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end

    // Request held through words; inputs scrambled while a word is in flight.
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      if (expQ.size() > 0) applyStimulus(1'b0, 1'b1, 16'($urandom), 4'($urandom));
      else                 applyStimulus(1'b0, 1'b1, 16'h8001, 4'd0);
    end
    for (int i = 0; i < 18; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end

    // Reset in the middle of a word, then a clean word.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 4'd0);
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, '0, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 16'h0003, 4'd0);
    for (int i = 0; i < 18; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end

    // Random traffic with occasional resets.
    hold = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      nextCycle();
      if ($urandom_range(0, 3) == 0) hold = 16'($urandom);
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), hold,
                    ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom));
    end
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
